ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 105 ++++++++++
 tb/tb_ram_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous data RAM.
// Define RAM_ARB_FAIR_EN for round-robin tie-breaking; otherwise A has fixed priority.
module ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0] state;
    logic       owner_b;
    logic       a_wins;

`ifdef RAM_ARB_FAIR_EN
    logic last_b;
    // On a tie the requester that did not win last time gets the RAM.
    assign a_wins = a_req && (!b_req || last_b);
`else
    assign a_wins = a_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_b   <= 1'b0;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
`ifdef RAM_ARB_FAIR_EN
            last_b    <= 1'b1;
`endif
        end else begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    ram_we <= 1'b0;
                    if (a_req || b_req) begin
                        owner_b   <= !a_wins;
                        ram_addr  <= a_wins ? a_addr  : b_addr;
                        ram_wdata <= a_wins ? a_wdata : b_wdata;
                        ram_we    <= a_wins ? a_we    : b_we;
                        a_gnt     <= a_wins;
                        b_gnt     <= !a_wins;
                        state     <= ISSUE;
`ifdef RAM_ARB_FAIR_EN
                        last_b    <= !a_wins;
`endif
                    end
                end
                ISSUE: begin
                    // ram_we still reflects the access being issued this cycle
                    ram_we <= 1'b0;
                    state  <= ram_we ? IDLE : WAIT;
                end
                WAIT: begin
                    if (owner_b) begin
                        b_rdata  <= ram_rdata;
                        b_rvalid <= 1'b1;
                    end else begin
                        a_rdata  <= ram_rdata;
                        a_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM model.
module tb_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_gnt, a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_gnt, b_rvalid;
    logic [DW-1:0] b_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int failures = 0;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we} !== 5'b0 || ram_addr !== '0 ||
            ram_wdata !== '0 || a_rdata !== '0 || b_rdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b we=%b addr=%h wd=%h ard=%h brd=%h, want all 0",
                     a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_addr, ram_wdata, a_rdata, b_rdata);
        end
    endtask

    task automatic test_write();
        a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 32'hDEADBEEF;
        tick();
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 8'h10 ||
            ram_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_issue: got gnt=%b/%b we=%b addr=%h wd=%h, want 1/0 1 10 deadbeef",
                     a_gnt, b_gnt, ram_we, ram_addr, ram_wdata);
        end
        a_req = 0; a_we = 0;
        tick();
        checks++;
        if (ram_we !== 1'b0 || a_gnt !== 1'b0) begin
            failures++;
            $display("FAIL write_done: got we=%b gnt=%b, want 0 0", ram_we, a_gnt);
        end
    endtask

    task automatic test_read_b();
        b_req = 1; b_we = 0; b_addr = 8'h10;
        tick();
        checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 8'h10) begin
            failures++;
            $display("FAIL read_b_gnt: got bgnt=%b agnt=%b we=%b addr=%h, want 1 0 0 10",
                     b_gnt, a_gnt, ram_we, ram_addr);
        end
        b_req = 0;
        tick();
        checks++;
        if (b_rvalid !== 1'b0 || b_gnt !== 1'b0) begin
            failures++;
            $display("FAIL read_b_wait: got rvalid=%b gnt=%b, want 0 0", b_rvalid, b_gnt);
        end
        tick();
        checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'hDEADBEEF || a_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL read_b_data: got brv=%b brd=%h arv=%b, want 1 deadbeef 0",
                     b_rvalid, b_rdata, a_rvalid);
        end
        tick();
        checks++;
        if (b_rvalid !== 1'b0 || b_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_b_hold: got rv=%b rd=%h, want 0 deadbeef", b_rvalid, b_rdata);
        end
    endtask

    task automatic test_tie();
        logic [2:0] exp_b;
`ifdef RAM_ARB_FAIR_EN
        exp_b = 3'b010;
`else
        exp_b = 3'b000;
`endif
        do_reset();
        a_req = 1; a_we = 1; a_addr = 8'h20; a_wdata = 32'hAAAA0000;
        b_req = 1; b_we = 1; b_addr = 8'h21; b_wdata = 32'hBBBB0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_gnt !== !exp_b[i] || b_gnt !== exp_b[i] ||
                ram_wdata !== (exp_b[i] ? 32'hBBBB0000 : 32'hAAAA0000)) begin
                failures++;
                $display("FAIL tie_grant%0d: got agnt=%b bgnt=%b wd=%h, want agnt=%b bgnt=%b",
                         i, a_gnt, b_gnt, ram_wdata, !exp_b[i], exp_b[i]);
            end
            tick();
        end
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        tick();
    endtask

    task automatic test_reset_abort();
        do_reset();
        a_req = 1; a_we = 0; a_addr = 8'h10;
        tick();
        a_req = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we} !== 5'b0 || a_rdata !== '0 || ram_addr !== '0) begin
            failures++;
            $display("FAIL abort_wait: got gnt=%b%b rv=%b%b we=%b ard=%h addr=%h, want all 0",
                     a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, a_rdata, ram_addr);
        end
        tick();
        checks++;
        if (a_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_rvalid: got %b, want 0", a_rvalid);
        end
        // a write aborted in ISSUE must drop ram_we right away
        a_req = 1; a_we = 1; a_addr = 8'h30; a_wdata = 32'h55;
        tick();
        checks++;
        if (a_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h30) begin
            failures++;
            $display("FAIL abort_regrant: got gnt=%b we=%b addr=%h, want 1 1 30", a_gnt, ram_we, ram_addr);
        end
        a_req = 0; a_we = 0;
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (ram_we !== 1'b0 || a_gnt !== 1'b0) begin
            failures++;
            $display("FAIL abort_issue: got we=%b gnt=%b, want 0 0", ram_we, a_gnt);
        end
    endtask

    task automatic test_read_stream();
        for (int i = 0; i < 4; i++) begin
            a_req = 1; a_we = 1; a_addr = AW'(i); a_wdata = DW'(i + 1);
            tick();
            a_req = 0; a_we = 0;
            tick();
        end
        a_req = 1; a_we = 0; a_addr = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (a_gnt !== 1'b1 || ram_addr !== AW'(i)) begin
                failures++;
                $display("FAIL stream_gnt%0d: got gnt=%b addr=%h, want 1 %h", i, a_gnt, ram_addr, i);
            end
            if (i < 3) a_addr = AW'(i + 1);
            else a_req = 0;
            tick();
            checks++;
            if (a_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL stream_early%0d: got rvalid=%b, want 0", i, a_rvalid);
            end
            tick();
            checks++;
            if (a_rvalid !== 1'b1 || a_rdata !== DW'(i + 1) || b_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL stream_data%0d: got rv=%b rd=%h brv=%b, want 1 %h 0",
                         i, a_rvalid, a_rdata, b_rvalid, i + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_b();
        test_tie();
        test_reset_abort();
        test_read_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
